// File: rtl/di_reg_file_term.sv
// di_reg_file_term
// Register-file terminal on the di_* host-interface bus, placed directly
// downstream of the i2c host interface. It answers one terminal address and
// serves 32-bit reads and writes to NUM_REGS registers. Reads use an
// auto-incrementing pointer and programmable wait states. Errors are reported
// on di_transfer_status so the host interface can NACK.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   di_term_addr         terminal address from host (matched against TERM_ADDR)
//   di_reg_addr          register address; only [7:0] is used
//   di_read_mode         read transaction active
//   di_read_req          pulse: start a read at di_reg_addr
//   di_read              pulse: current read word consumed, fetch next
//   di_write_mode        write transaction active
//   di_write             pulse: write di_reg_datai to di_reg_addr
//   di_reg_datai         write data
//   di_read_rdy          di_reg_datao valid
//   di_reg_datao         read data, held until the next load
//   di_write_rdy         ready for the next write
//   di_transfer_status   0=OK, 1=ERR_RANGE, 2=ERR_READONLY (sticky per transaction)
//   reg_q                flattened register contents, reg i at [32*i+31:32*i]
//   wr_strobe            one-cycle pulse on the cycle after register i is written
//   dbg_state            FSM state: 0=IDLE, 1=RD_WAIT, 2=RD_VALID, 3=WR_WAIT
//
// Handshake: read data is valid while di_read_rdy=1; a di_read pulse while
// valid consumes the word and drops di_read_rdy until the next word is
// fetched. A di_write pulse is accepted only while di_write_rdy=1 (IDLE);
// di_write_rdy then stays low for WR_LATENCY cycles. All pulses are ignored
// unless the terminal is selected and a transaction (read or write mode) is open.
module di_reg_file_term #(
  parameter logic [15:0] TERM_ADDR  = 16'h0050,
  parameter int          NUM_REGS   = 16,
  parameter int          RD_LATENCY = 2,
  parameter int          WR_LATENCY = 1,
  parameter logic [31:0] ID_VALUE   = 32'h4E495452
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              di_term_addr,
  input  logic [31:0]              di_reg_addr,
  input  logic                     di_read_mode,
  input  logic                     di_read_req,
  input  logic                     di_read,
  input  logic                     di_write_mode,
  input  logic                     di_write,
  input  logic [31:0]              di_reg_datai,
  output logic                     di_read_rdy,
  output logic [31:0]              di_reg_datao,
  output logic                     di_write_rdy,
  output logic [15:0]              di_transfer_status,
  output logic [32*NUM_REGS-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      wr_strobe,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RD_WAIT  = 2'd1,
    S_RD_VALID = 2'd2,
    S_WR_WAIT  = 2'd3
  } state_t;

  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);
  localparam logic [3:0] RD_CNT     = 4'(RD_LATENCY - 1);
  localparam logic [3:0] WR_CNT     = 4'(WR_LATENCY - 1);

  localparam logic [15:0] ST_OK       = 16'd0;
  localparam logic [15:0] ST_RANGE    = 16'd1;
  localparam logic [15:0] ST_READONLY = 16'd2;

  state_t                state_q;
  logic [7:0]            ptr_q;
  logic [3:0]            cnt_q;
  logic                  rd_rdy_q;
  logic                  wr_rdy_q;
  logic [31:0]           datao_q;
  logic [15:0]           status_q;
  logic [NUM_REGS-1:0]   strobe_q;
  // Register 0 is the read-only ID word, so storage starts at index 1.
  logic [31:0]           regs_q [1:NUM_REGS-1];

  logic                  sel;
  logic                  active;
  logic [7:0]            wr_idx;
  logic                  wr_oob;
  logic                  rd_oob;
  logic [31:0]           rd_word;
  logic                  unused_addr_bits;

  assign sel    = (di_term_addr == TERM_ADDR);
  // Dropping both mode lines closes the transaction; it is also the only
  // thing that clears a sticky error status.
  assign active = sel && (di_read_mode || di_write_mode);
  assign wr_idx = di_reg_addr[7:0];
  assign wr_oob = ({1'b0, wr_idx} >= NUM_REGS_W);
  assign rd_oob = ({1'b0, ptr_q} >= NUM_REGS_W);
  assign unused_addr_bits = ^di_reg_addr[31:8];

  // Fetch mux; anything beyond the register file reads as a poison word.
  always_comb begin
    rd_word = 32'hDEADBEEF;
    if (ptr_q == 8'd0) rd_word = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (ptr_q == 8'(i)) rd_word = regs_q[i];
    end
  end

  always_comb begin
    reg_q = '0;
    reg_q[31:0] = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      reg_q[32*i +: 32] = regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      rd_rdy_q <= 1'b1;
      wr_rdy_q <= 1'b1;
      datao_q  <= '0;
      status_q <= ST_OK;
      strobe_q <= '0;
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      strobe_q <= '0;
      if (!active) begin
        state_q  <= S_IDLE;
        status_q <= ST_OK;
        rd_rdy_q <= 1'b1;
        wr_rdy_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            // A write beats a simultaneous read request.
            if (di_write) begin
              wr_rdy_q <= 1'b0;
              cnt_q    <= WR_CNT;
              state_q  <= S_WR_WAIT;
              if (wr_oob) begin
                status_q <= ST_RANGE;
              end else if (wr_idx == 8'd0) begin
                status_q <= ST_READONLY;
              end else begin
                for (int i = 1; i < NUM_REGS; i++) begin
                  if (wr_idx == 8'(i)) begin
                    regs_q[i]   <= di_reg_datai;
                    strobe_q[i] <= 1'b1;
                  end
                end
              end
            end else if (di_read_req) begin
              ptr_q    <= wr_idx;
              rd_rdy_q <= 1'b0;
              cnt_q    <= RD_CNT;
              state_q  <= S_RD_WAIT;
            end
          end
          S_RD_WAIT: begin
            if (di_read_req) begin
              // Restart the fetch at the new address.
              ptr_q <= wr_idx;
              cnt_q <= RD_CNT;
            end else if (cnt_q == 4'd0) begin
              datao_q  <= rd_word;
              rd_rdy_q <= 1'b1;
              state_q  <= S_RD_VALID;
              if (rd_oob) status_q <= ST_RANGE;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          S_RD_VALID: begin
            if (di_read_req) begin
              ptr_q    <= wr_idx;
              rd_rdy_q <= 1'b0;
              cnt_q    <= RD_CNT;
              state_q  <= S_RD_WAIT;
            end else if (di_read) begin
              ptr_q    <= ptr_q + 8'd1;  // wraps 255 -> 0
              rd_rdy_q <= 1'b0;
              cnt_q    <= RD_CNT;
              state_q  <= S_RD_WAIT;
            end
          end
          S_WR_WAIT: begin
            // Writes arriving here are dropped.
            if (cnt_q == 4'd0) begin
              wr_rdy_q <= 1'b1;
              state_q  <= S_IDLE;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign di_read_rdy        = rd_rdy_q;
  assign di_reg_datao       = datao_q;
  assign di_write_rdy       = wr_rdy_q;
  assign di_transfer_status = status_q;
  assign wr_strobe          = strobe_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_di_reg_file_term.sv
module tb_di_reg_file_term;

  localparam int NR = 16;

  // control bits for vector records: {alt_term, rm, rq, rd, wm, wr}
  localparam logic [5:0] NO  = 6'b000000;
  localparam logic [5:0] WR  = 6'b000001;
  localparam logic [5:0] WM  = 6'b000010;
  localparam logic [5:0] RD  = 6'b000100;
  localparam logic [5:0] RQ  = 6'b001000;
  localparam logic [5:0] RM  = 6'b010000;
  localparam logic [5:0] ALT = 6'b100000;

  localparam logic [1:0] F_I  = 2'd0;
  localparam logic [1:0] F_RW = 2'd1;
  localparam logic [1:0] F_RV = 2'd2;
  localparam logic [1:0] F_WW = 2'd3;

  localparam logic [31:0] ID  = 32'h4E495452;
  localparam logic [31:0] BAD = 32'hDEADBEEF;
  localparam logic [31:0] VA  = 32'h11112222;
  localparam logic [31:0] VB  = 32'h12345678;
  localparam logic [31:0] VC  = 32'h33334444;

  // clock/reset and DUT signals
  logic              clk = 1'b0;
  logic              reset;
  logic [15:0]       di_term_addr;
  logic [31:0]       di_reg_addr;
  logic              di_read_mode, di_read_req, di_read;
  logic              di_write_mode, di_write;
  logic [31:0]       di_reg_datai;
  logic              di_read_rdy;
  logic [31:0]       di_reg_datao;
  logic              di_write_rdy;
  logic [15:0]       di_transfer_status;
  logic [32*NR-1:0]  reg_q;
  logic [NR-1:0]     wr_strobe;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  di_reg_file_term dut (
    .clk                (clk),
    .reset              (reset),
    .di_term_addr       (di_term_addr),
    .di_reg_addr        (di_reg_addr),
    .di_read_mode       (di_read_mode),
    .di_read_req        (di_read_req),
    .di_read            (di_read),
    .di_write_mode      (di_write_mode),
    .di_write           (di_write),
    .di_reg_datai       (di_reg_datai),
    .di_read_rdy        (di_read_rdy),
    .di_reg_datao       (di_reg_datao),
    .di_write_rdy       (di_write_rdy),
    .di_transfer_status (di_transfer_status),
    .reg_q              (reg_q),
    .wr_strobe          (wr_strobe),
    .dbg_state          (dbg_state)
  );

  typedef struct {
    logic [5:0]  ctl;
    logic [31:0] ra;
    logic [31:0] d;
    logic        e_rr;
    logic        e_wr;
    logic [15:0] e_st;
    logic [1:0]  e_fsm;
    logic [15:0] e_stb;
    logic        chk_d;
    logic [31:0] e_d;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // scoreboard comparison
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic [5:0] ctl, input logic [31:0] ra, input logic [31:0] d,
                              input logic e_rr, input logic e_wr, input logic [15:0] e_st,
                              input logic [1:0] e_fsm, input logic [15:0] e_stb,
                              input logic chk_d, input logic [31:0] e_d);
    vec_t v;
    v.ctl = ctl; v.ra = ra; v.d = d; v.e_rr = e_rr; v.e_wr = e_wr; v.e_st = e_st;
    v.e_fsm = e_fsm; v.e_stb = e_stb; v.chk_d = chk_d; v.e_d = e_d;
    vq.push_back(v);
  endfunction

  // driver tasks
  task automatic drive(input logic [5:0] ctl, input logic [31:0] ra, input logic [31:0] d);
    di_term_addr  = ctl[5] ? 16'h0051 : 16'h0050;
    di_read_mode  = ctl[4];
    di_read_req   = ctl[3];
    di_read       = ctl[2];
    di_write_mode = ctl[1];
    di_write      = ctl[0];
    di_reg_addr   = ra;
    di_reg_datai  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string nm, input int idx, input logic [31:0] exp);
    chk(nm, reg_q[32*idx +: 32], exp);
  endtask

  initial begin
    // reset block
    reset = 1'b1;
    drive(NO, 0, 0);
    tick();
    tick();
    chk("rst rd_rdy", 32'(di_read_rdy), 32'd1);
    chk("rst wr_rdy", 32'(di_write_rdy), 32'd1);
    chk("rst status", 32'(di_transfer_status), 32'd0);
    chk("rst fsm", 32'(dbg_state), 32'(F_I));
    chk("rst strobe", 32'(wr_strobe), 32'd0);
    chk("rst datao", di_reg_datao, 32'd0);
    chk_reg("rst reg0", 0, ID);
    for (int i = 1; i < NR; i++) chk_reg($sformatf("rst reg%0d", i), i, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // directed vectors: ctl, addr, data | rd_rdy, wr_rdy, status, fsm, strobe, chk_datao, datao
    add(WM|WR, 3, VB,             1,0,0,F_WW,16'h0008,0,0);   // write reg3
    add(WM, 0, 0,                 1,1,0,F_I, 16'h0000,0,0);
    add(WM|WR, 2, VA,             1,0,0,F_WW,16'h0004,0,0);
    add(WM, 0, 0,                 1,1,0,F_I, 16'h0000,0,0);
    add(WM|WR, 4, VC,             1,0,0,F_WW,16'h0010,0,0);
    add(WM, 0, 0,                 1,1,0,F_I, 16'h0000,0,0);
    add(NO, 0, 0,                 1,1,0,F_I, 16'h0000,0,0);
    add(RM|RQ, 2, 0,              0,1,0,F_RW,16'h0000,0,0);   // read burst from 2
    add(RM, 0, 0,                 0,1,0,F_RW,16'h0000,0,0);
    add(RM, 0, 0,                 1,1,0,F_RV,16'h0000,1,VA);
    add(RM|RD, 0, 0,              0,1,0,F_RW,16'h0000,0,0);
    add(RM, 0, 0,                 0,1,0,F_RW,16'h0000,0,0);
    add(RM, 0, 0,                 1,1,0,F_RV,16'h0000,1,VB);
    add(RM|RD, 0, 0,              0,1,0,F_RW,16'h0000,0,0);
    add(RM, 0, 0,                 0,1,0,F_RW,16'h0000,0,0);
    add(RM, 0, 0,                 1,1,0,F_RV,16'h0000,1,VC);
    add(RM, 0, 0,                 1,1,0,F_RV,16'h0000,1,VC);
    add(NO, 0, 0,                 1,1,0,F_I, 16'h0000,1,VC);  // datao holds
    add(WM|WR, 20, 32'hFFFFFFFF,  1,0,1,F_WW,16'h0000,0,0);   // range error
    add(WM, 0, 0,                 1,1,1,F_I, 16'h0000,0,0);
    add(WM|WR, 0, 32'hDEAD0000,   1,0,2,F_WW,16'h0000,0,0);   // read-only error
    add(WM, 0, 0,                 1,1,2,F_I, 16'h0000,0,0);
    add(NO, 0, 0,                 1,1,0,F_I, 16'h0000,0,0);
    add(WM|WR, 32'hABCD0105, 32'h55, 1,0,0,F_WW,16'h0020,0,0); // upper addr bits ignored
    add(WM, 0, 0,                 1,1,0,F_I, 16'h0000,0,0);
    add(NO, 0, 0,                 1,1,0,F_I, 16'h0000,0,0);
    add(RM|RQ, 16, 0,             0,1,0,F_RW,16'h0000,0,0);   // read out of range
    add(RM, 0, 0,                 0,1,0,F_RW,16'h0000,0,0);
    add(RM, 0, 0,                 1,1,1,F_RV,16'h0000,1,BAD);
    add(RM, 0, 0,                 1,1,1,F_RV,16'h0000,1,BAD);
    add(NO, 0, 0,                 1,1,0,F_I, 16'h0000,1,BAD);
    add(RM|RQ, 0, 0,              0,1,0,F_RW,16'h0000,0,0);   // read ID
    add(RM, 0, 0,                 0,1,0,F_RW,16'h0000,0,0);
    add(RM, 0, 0,                 1,1,0,F_RV,16'h0000,1,ID);
    add(NO, 0, 0,                 1,1,0,F_I, 16'h0000,0,0);
    add(ALT|WM|WR, 6, 32'h66,     1,1,0,F_I, 16'h0000,0,0);   // wrong terminal
    add(ALT|WM, 0, 0,             1,1,0,F_I, 16'h0000,0,0);
    add(RM|RQ|WM|WR, 7, 32'h77,   1,0,0,F_WW,16'h0080,0,0);   // write beats read_req
    add(RM|WM, 0, 0,              1,1,0,F_I, 16'h0000,0,0);
    add(NO, 0, 0,                 1,1,0,F_I, 16'h0000,0,0);
    add(WM|WR, 8, 32'h88,         1,0,0,F_WW,16'h0100,0,0);
    add(WM|WR, 9, 32'h99,         1,1,0,F_I, 16'h0000,0,0);   // ignored in WR_WAIT
    add(NO, 0, 0,                 1,1,0,F_I, 16'h0000,0,0);
    add(RM|RQ, 3, 0,              0,1,0,F_RW,16'h0000,0,0);
    add(RM|RQ, 4, 0,              0,1,0,F_RW,16'h0000,0,0);   // restart in RD_WAIT
    add(RM, 0, 0,                 0,1,0,F_RW,16'h0000,0,0);
    add(RM, 0, 0,                 1,1,0,F_RV,16'h0000,1,VC);
    add(NO, 0, 0,                 1,1,0,F_I, 16'h0000,0,0);
    add(RM|RQ, 15, 0,             0,1,0,F_RW,16'h0000,0,0);   // last reg then past end
    add(RM, 0, 0,                 0,1,0,F_RW,16'h0000,0,0);
    add(RM, 0, 0,                 1,1,0,F_RV,16'h0000,1,32'd0);
    add(RM|RD, 0, 0,              0,1,0,F_RW,16'h0000,0,0);
    add(RM, 0, 0,                 0,1,0,F_RW,16'h0000,0,0);
    add(RM, 0, 0,                 1,1,1,F_RV,16'h0000,1,BAD);
    add(NO, 0, 0,                 1,1,0,F_I, 16'h0000,0,0);
    add(RM|RQ, 32'hFF, 0,         0,1,0,F_RW,16'h0000,0,0);   // pointer wrap 255 -> 0
    add(RM, 0, 0,                 0,1,0,F_RW,16'h0000,0,0);
    add(RM, 0, 0,                 1,1,1,F_RV,16'h0000,1,BAD);
    add(RM|RD, 0, 0,              0,1,1,F_RW,16'h0000,0,0);
    add(RM, 0, 0,                 0,1,1,F_RW,16'h0000,0,0);
    add(RM, 0, 0,                 1,1,1,F_RV,16'h0000,1,ID);
    add(NO, 0, 0,                 1,1,0,F_I, 16'h0000,0,0);

    foreach (vq[k]) begin
      @(negedge clk);
      drive(vq[k].ctl, vq[k].ra, vq[k].d);
      tick();
      chk($sformatf("v%0d rd_rdy", k), 32'(di_read_rdy), 32'(vq[k].e_rr));
      chk($sformatf("v%0d wr_rdy", k), 32'(di_write_rdy), 32'(vq[k].e_wr));
      chk($sformatf("v%0d status", k), 32'(di_transfer_status), 32'(vq[k].e_st));
      chk($sformatf("v%0d fsm", k), 32'(dbg_state), 32'(vq[k].e_fsm));
      chk($sformatf("v%0d strobe", k), 32'(wr_strobe), 32'(vq[k].e_stb));
      if (vq[k].chk_d) chk($sformatf("v%0d datao", k), di_reg_datao, vq[k].e_d);
    end

    // register contents after the vector run
    chk_reg("end reg0", 0, ID);
    chk_reg("end reg1", 1, 32'd0);
    chk_reg("end reg2", 2, VA);
    chk_reg("end reg3", 3, VB);
    chk_reg("end reg4", 4, VC);
    chk_reg("end reg5", 5, 32'h55);
    chk_reg("end reg6", 6, 32'd0);
    chk_reg("end reg7", 7, 32'h77);
    chk_reg("end reg8", 8, 32'h88);
    chk_reg("end reg9", 9, 32'd0);
    chk_reg("end reg15", 15, 32'd0);

    // reset while in WR_WAIT
    @(negedge clk);
    drive(WM|WR, 10, 32'hAAAA000A);
    tick();
    chk("wrw fsm", 32'(dbg_state), 32'(F_WW));
    chk("wrw strobe", 32'(wr_strobe), 32'h0400);
    @(negedge clk);
    reset = 1'b1;
    drive(WM, 0, 0);
    tick();
    chk("wrw rst fsm", 32'(dbg_state), 32'(F_I));
    chk("wrw rst rdys", {30'd0, di_read_rdy, di_write_rdy}, 32'd3);
    chk("wrw rst strobe", 32'(wr_strobe), 32'd0);
    chk_reg("wrw rst reg10", 10, 32'd0);

    // reset coincident with a write: nothing committed
    @(negedge clk);
    drive(WM|WR, 11, 32'hBBBB000B);
    tick();
    chk("rstw strobe", 32'(wr_strobe), 32'd0);
    chk_reg("rstw reg11", 11, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(NO, 0, 0);
    tick();
    chk("rstw after strobe", 32'(wr_strobe), 32'd0);
    chk_reg("rstw after reg11", 11, 32'd0);

    // reset while in RD_WAIT
    @(negedge clk);
    drive(RM|RQ, 0, 0);
    tick();
    chk("rdw fsm", 32'(dbg_state), 32'(F_RW));
    chk("rdw rd_rdy", 32'(di_read_rdy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(RM, 0, 0);
    tick();
    chk("rdw rst fsm", 32'(dbg_state), 32'(F_I));
    chk("rdw rst rdys", {30'd0, di_read_rdy, di_write_rdy}, 32'd3);
    chk("rdw rst datao", di_reg_datao, 32'd0);
    chk("rdw rst status", 32'(di_transfer_status), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(NO, 0, 0);
    tick();
    chk("rdw after strobe", 32'(wr_strobe), 32'd0);
    chk("rdw after fsm", 32'(dbg_state), 32'(F_I));

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
